// File: rtl/div16u8u_seq.sv
// div16u8u_seq: exact sequential unsigned divider, DW-bit dividend / VW-bit divisor.
// Radix-2 restoring: one quotient bit per clock, valid/ready handshake both sides.
// A zero divisor skips the iteration and reports Q=all ones, R=A[VW-1:0], DZ=1.
module div16u8u_seq #(
    parameter int unsigned DW = 16,
    parameter int unsigned VW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] A,
    input  logic [VW-1:0] B,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] Q,
    output logic [VW-1:0] R,
    output logic          DZ
);

    localparam int unsigned CW = $clog2(DW + 1);
    localparam int unsigned PW = VW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;

    // Quotient shift register: dividend bits shift out the top, quotient bits enter the bottom
    logic [DW-1:0] qsr;
    logic [DW-1:0] qsr_n;
    // Partial remainder; always < divisor between steps, so VW bits hold it
    logic [VW-1:0] rem;
    logic [VW-1:0] rem_n;
    logic [VW-1:0] div;
    logic [VW-1:0] div_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [DW-1:0] q_n;
    logic [VW-1:0] r_n;
    logic          dz_n;

    // Shifted partial remainder carries one extra bit so the compare never overflows
    logic [PW-1:0] p;
    logic          ge;

    // Next-state and datapath update
    always_comb begin
        state_n = state;
        qsr_n   = qsr;
        rem_n   = rem;
        div_n   = div;
        cnt_n   = cnt;
        q_n     = Q;
        r_n     = R;
        dz_n    = DZ;
        p       = {rem, qsr[DW-1]};
        ge      = (p >= {1'b0, div});

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    qsr_n = A;
                    rem_n = '0;
                    div_n = B;
                    cnt_n = CW'(DW);
                    if (B == '0) begin
                        state_n = DONE;
                        q_n     = '1;
                        r_n     = A[VW-1:0];
                        dz_n    = 1'b1;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                qsr_n = {qsr[DW-2:0], ge};
                rem_n = ge ? VW'(p - {1'b0, div}) : VW'(p);
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = DONE;
                    q_n     = qsr_n;
                    r_n     = rem_n;
                    dz_n    = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            qsr       <= '0;
            rem       <= '0;
            div       <= '0;
            cnt       <= '0;
            Q         <= '0;
            R         <= '0;
            DZ        <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            qsr       <= qsr_n;
            rem       <= rem_n;
            div       <= div_n;
            cnt       <= cnt_n;
            Q         <= q_n;
            R         <= r_n;
            DZ        <= dz_n;
            in_ready  <= (state_n == IDLE);
            out_valid <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_div16u8u_seq.sv
// Bench for div16u8u_seq: directed literal vectors plus a scoreboard that
// recomputes every result with plain division and checks it each cycle.
module tb_div16u8u_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [7:0]  B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Q;
    logic [7:0]  R;
    logic        DZ;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        int unsigned cyc;
    } op_t;

    op_t         exp_q[$];
    int          n_cmp   = 0;
    int          n_err   = 0;
    int          n_acc   = 0;
    int          n_res   = 0;
    int          n_flush = 0;
    int unsigned cyc     = 0;
    bit          seen    = 1'b0;

    div16u8u_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .DZ        (DZ)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_q(input logic [15:0] a, input logic [7:0] b);
        return (b == 8'd0) ? 16'hFFFF : a / {8'd0, b};
    endfunction

    function automatic logic [7:0] model_r(input logic [15:0] a, input logic [7:0] b);
        logic [15:0] m;
        m = (b == 8'd0) ? a : a % {8'd0, b};
        return m[7:0];
    endfunction

    // Scoreboard: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        op_t e;
        if (rst) begin
            n_flush += exp_q.size();
            exp_q.delete();
            seen = 1'b0;
        end else begin
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                check("in_ready_busy", 32'(in_ready), 32'd0);
                if (out_valid) begin
                    if (!seen) begin
                        // rising edge of out_valid: 16 edges after accept, or straight away for B==0
                        check("sb_latency", cyc - e.cyc, (e.b == 8'd0) ? 32'd1 : 32'd17);
                        seen = 1'b1;
                    end
                    check("sb_q", 32'(Q), 32'(model_q(e.a, e.b)));
                    check("sb_r", 32'(R), 32'(model_r(e.a, e.b)));
                    check("sb_dz", 32'(DZ), (e.b == 8'd0) ? 32'd1 : 32'd0);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                        n_res++;
                    end
                end
            end else begin
                check("sb_spurious_valid", 32'(out_valid), 32'd0);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{a: A, b: B, cyc: cyc});
                n_acc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation with literal expectations; hold = cycles of backpressure in DONE
    task automatic do_op(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                         input logic [7:0] er, input logic edz, input int hold);
        int n;
        A = a;
        B = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        // edges after the accept edge before out_valid is seen
        check("lat_edges", 32'(n), (b == 8'd0) ? 32'd0 : 32'd16);
        check("lit_q", 32'(Q), 32'(eq));
        check("lit_r", 32'(R), 32'(er));
        check("lit_dz", 32'(DZ), 32'(edz));
        for (int i = 0; i < hold; i++) begin
            A = 16'($urandom);
            B = 8'($urandom_range(1, 255));
            in_valid = i[0];
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready), 32'd0);
            check("hold_q", 32'(Q), 32'(eq));
            check("hold_r", 32'(R), 32'(er));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drop_valid", 32'(out_valid), 32'd0);
        check("idle_ready", 32'(in_ready), 32'd1);
        check("keep_q", 32'(Q), 32'(eq));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit hs;
        rst = 1'b1;
        in_valid = 1'b1;
        A = 16'd77;
        B = 8'd7;
        out_ready = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", 32'(Q), 32'd0);
        check("rst_r", 32'(R), 32'd0);
        check("rst_dz", 32'(DZ), 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        check("post_rst_ready", 32'(in_ready), 32'd1);

        do_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 0);
        do_op(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 0);
        do_op(16'd200, 8'd201, 16'd0, 8'd200, 1'b0, 0);
        do_op(16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 0);
        do_op(16'd5, 8'd0, 16'hFFFF, 8'd5, 1'b1, 0);
        do_op(16'd9, 8'd3, 16'd3, 8'd0, 1'b0, 0);
        do_op(16'd4660, 8'd13, 16'd358, 8'd6, 1'b0, 5);

        // Reset during RUN discards the operation; operands presented under reset are ignored
        A = 16'd50000;
        B = 8'd3;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        in_valid = 1'b1;
        A = 16'd100;
        B = 8'd5;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check("midrun_rst_valid", 32'(out_valid), 32'd0);
        check("midrun_rst_q", 32'(Q), 32'd0);
        check("midrun_rst_r", 32'(R), 32'd0);
        tick();
        check("midrun_post_ready", 32'(in_ready), 32'd1);
        repeat (20) tick();
        do_op(16'd50000, 8'd3, 16'd16666, 8'd2, 1'b0, 0);

        // Random operands, input gaps and output backpressure; scoreboard checks results
        for (int k = 0; k < 2500; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            A = 16'($urandom);
            B = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 40) begin
                tick();
                n++;
            end
            tick();
            in_valid = 1'b0;
            n = 0;
            hs = 1'b0;
            while (!hs && n < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                hs = out_valid && out_ready;
                tick();
                n++;
            end
            out_ready = 1'b0;
            if (!hs) check("rand_handshake", 32'd0, 32'd1);
        end
        repeat (3) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("result_count", 32'(n_res + n_flush), 32'(n_acc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
